// File: rtl/gemm_mem_arbiter.sv
// gemm_mem_arbiter
// -----------------------------------------------------------------------------
// Shares the single DATA_W-bit GEMM memory interface between the load/prefetch
// requester and the store requester. A granted burst descriptor is issued
// beat by beat, with the address advancing by DATA_W/8 bytes per beat. One
// GAP bubble separates consecutive bursts. A burst is never preempted.
//
// Optional feature (macro GEMM_ARB_STARVE_GUARD_EN):
//   When defined, a saturating starve counter lets a waiting load win over a
//   store once the load has waited STARVE_MAX cycles.
//   When undefined, store has strict priority and no counter exists.
//
// Ports:
//   clk, rst               clock; synchronous active-high reset
//   ld_req/ld_addr/ld_beats  load burst descriptor (0 beats means 1)
//   ld_gnt/ld_beat/ld_done   load grant pulse, per-beat strobe, last-beat pulse
//   st_req/st_addr/st_beats  store burst descriptor
//   st_wr_data               store data for the current beat
//   st_gnt/st_beat/st_done   store equivalents of the load strobes
//   interface_en             one memory access strobe per beat
//   interface_rdwr           0 = read (load), 1 = write (store)
//   interface_addr           beat address (wraps modulo 2^ADDR_W)
//   interface_control        beats remaining, including the current beat
//   interface_wr_data        st_wr_data during store beats, else 0
//   busy                     arbiter is not idle
// -----------------------------------------------------------------------------
module gemm_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 128,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [4:0]        ld_beats,
  output logic              ld_gnt,
  output logic              ld_beat,
  output logic              ld_done,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [4:0]        st_beats,
  input  logic [DATA_W-1:0] st_wr_data,
  output logic              st_gnt,
  output logic              st_beat,
  output logic              st_done,
  output logic              interface_en,
  output logic              interface_rdwr,
  output logic [ADDR_W-1:0] interface_addr,
  output logic [4:0]        interface_control,
  output logic [DATA_W-1:0] interface_wr_data,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, LOAD, STORE, GAP} state_t;

  localparam logic [ADDR_W-1:0] BEAT_BYTES = ADDR_W'(DATA_W / 8);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;   // address of the current beat
  logic [4:0]        cnt_q, cnt_d;     // beats remaining incl. current
  logic              first_q, first_d; // current beat is the first of the burst
  logic              force_ld;         // starvation guard overrides store priority

  function automatic logic [4:0] norm_beats(input logic [4:0] b);
    return (b == 5'd0) ? 5'd1 : b;
  endfunction

`ifdef GEMM_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [SW-1:0] starve_q;

  // Counts cycles a load request waits ungranted; saturates at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else if (ld_gnt) begin
      starve_q <= '0;
    end else if (ld_req && (starve_q != STARVE_LIM)) begin
      starve_q <= starve_q + SW'(1);
    end
  end

  assign force_ld = ld_req && (starve_q == STARVE_LIM);
`else
  // Strict store priority: STARVE_MAX has no effect, so this is constant 0.
  assign force_ld = ld_req && (STARVE_MAX < 0);
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  // All burst registers are reset, so a reset mid-burst discards the latched
  // descriptor and the beat counter restarts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d           = state_q;
    addr_d            = addr_q;
    cnt_d             = cnt_q;
    first_d           = first_q;
    ld_gnt            = 1'b0;
    ld_beat           = 1'b0;
    ld_done           = 1'b0;
    st_gnt            = 1'b0;
    st_beat           = 1'b0;
    st_done           = 1'b0;
    interface_en      = 1'b0;
    interface_rdwr    = 1'b0;
    interface_addr    = '0;
    interface_control = 5'd0;
    interface_wr_data = '0;
    busy              = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        // Store first (it frees accumulator buffers) unless load is starving.
        if (st_req && !force_ld) begin
          state_d = STORE;
          addr_d  = st_addr;
          cnt_d   = norm_beats(st_beats);
          first_d = 1'b1;
        end else if (ld_req) begin
          state_d = LOAD;
          addr_d  = ld_addr;
          cnt_d   = norm_beats(ld_beats);
          first_d = 1'b1;
        end
      end

      LOAD, STORE: begin
        interface_en      = 1'b1;
        interface_rdwr    = (state_q == STORE);
        interface_addr    = addr_q;
        interface_control = cnt_q;
        if (state_q == STORE) begin
          st_gnt            = first_q;
          st_beat           = 1'b1;
          st_done           = (cnt_q == 5'd1);
          interface_wr_data = st_wr_data;
        end else begin
          ld_gnt  = first_q;
          ld_beat = 1'b1;
          ld_done = (cnt_q == 5'd1);
        end
        first_d = 1'b0;
        addr_d  = addr_q + BEAT_BYTES;
        cnt_d   = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = GAP;
        end
      end

      GAP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: doc/gemm_mem_arbiter.md
# gemm_mem_arbiter

Arbitrates the single 128-bit GEMM memory interface between the load/prefetch requester and the store requester. Each requester presents a burst descriptor (base address, direction, beat count). The arbiter grants one requester at a time, issues the burst beat by beat with auto-incremented addresses, and signals completion. It sits between the load/execute controller, the store controller and the top-level `interface_*` ports. It replaces the ad-hoc address mux with a locked, starvation-aware sequencer.

## Interface
Parameters:
- `ADDR_W`, 32: address width (byte addresses).
- `DATA_W`, 128: beat width; the address increments by DATA_W/8 = 16 per beat.
- `STARVE_MAX`, 8: consecutive load-waiting cycles before load is forced ahead (guard only).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `ld_req`  in  1  load burst request; held until `ld_gnt`.
- `ld_addr`  in  ADDR_W  load burst base address.
- `ld_beats`  in  5  load beat count, 1..16; 0 is treated as 1.
- `ld_gnt`  out  1  one-cycle pulse: load descriptor accepted.
- `ld_beat`  out  1  a load read beat is issued this cycle.
- `ld_done`  out  1  one-cycle pulse on the last load beat.
- `st_req`, `st_addr`, `st_beats`  in  1/ADDR_W/5  store equivalents.
- `st_wr_data`  in  DATA_W  store data for the current beat.
- `st_gnt`, `st_beat`, `st_done`  out  1 each  store equivalents; `st_beat` tells the store side to advance its data.
- `interface_en`  out  1  memory access strobe, one per beat.
- `interface_rdwr`  out  1  0 = read (load), 1 = write (store).
- `interface_addr`  out  ADDR_W  beat address.
- `interface_control`  out  5  beats remaining, including the current one.
- `interface_wr_data`  out  DATA_W  equals `st_wr_data` during store beats, else 0.
- `busy`  out  1  the FSM is not in IDLE.

## Operation
- FSM states: IDLE, LOAD, STORE, GAP.
- In IDLE, the arbiter samples `ld_req`/`st_req` and picks a winner.
  - Default priority: store first, because it frees accumulator buffers.
  - The winner's address and beat count are latched. Next state is LOAD or STORE.
  - The matching `*_gnt` pulses in the first beat cycle.
- In LOAD/STORE, `interface_en`=1 every cycle.
  - Address = base + 16 × beat index.
  - The 5-bit beat counter counts down.
  - `*_beat` is high on every beat.
  - `*_done` is high on the final beat, together with `interface_en`.
  - The next state after the final beat is GAP.
- GAP lasts one cycle with `interface_en`=0, then the FSM returns to IDLE. This gives one bubble between bursts.
- A burst is never preempted. Requests arriving mid-burst wait.
- Requesters drop `*_req` in the cycle after `*_gnt`. A `*_req` still high in GAP/IDLE after `*_done` is a new request.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is silent.

## Timing
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - Beat counter and starve counter are 0.
- Latency:
  - `req` seen high in IDLE at edge N → first beat (`interface_en`=1, `*_gnt`=1) in cycle N+1.
  - A burst of B beats occupies cycles N+1..N+B.
  - GAP is cycle N+B+1; the earliest next grant is at N+B+3.
- Simultaneous `ld_req` and `st_req` in IDLE: store wins unless the starvation guard forces load.
- `rst` asserted mid-burst: next cycle is IDLE with all outputs 0. No `*_done` is generated. The latched descriptor is discarded.
- `interface_control` in the first beat equals the latched beat count, and decrements by 1 per beat down to 1.

## Configuration
- Macro `GEMM_ARB_STARVE_GUARD_EN`.
- Defined:
  - A starve counter increments each cycle `ld_req`=1 while not granted. It saturates at STARVE_MAX and clears on `ld_gnt`.
  - When the counter equals STARVE_MAX in IDLE, load wins even if `st_req`=1.
- Undefined:
  - Strict store priority; no counter logic is present.
  - A continuously requesting store side may starve load indefinitely.

## Test plan
- Single load: `ld_req`, `ld_addr`=0x1000, `ld_beats`=4 → `interface_en` for 4 cycles.
  - Addresses 0x1000/0x1010/0x1020/0x1030; `rdwr`=0; control 4,3,2,1.
  - `ld_done` on the 4th beat, then a GAP cycle.
- Single store: `st_addr`=0x2000, `st_beats`=2 → `rdwr`=1, two beats.
  - `interface_wr_data` tracks `st_wr_data` each beat; `st_done` on beat 2.
- Simultaneous requests: load 3 beats, store 1 beat → store is granted first (1 beat).
  - Then GAP, IDLE, and load is granted at cycle 4 after the initial sample.
- Starvation (macro defined, STARVE_MAX=8): `st_req` held continuously with 1-beat bursts, `ld_req` high.
  - Load is granted after its starve counter reaches 8.
  - With the macro undefined, load is never granted.
- Reset mid-burst: `rst` at beat 2 of an 8-beat load → next cycle all outputs 0, `busy`=0, and no `ld_done`.
- Zero/wrap: `ld_beats`=0 with `ld_addr`=0xFFFFFFF0 → exactly 1 beat at 0xFFFFFFF0. A 2-beat burst from the same address wraps to 0x00000000.
